// File: rtl/flash_pkg.sv
// Shared flash opcode constants, scheduler state encoding and opcode helpers.
// Pure declarations, no latency.
// No flow control; the SPI engine reuses the same opcode constants.
package flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_PP4  = 8'h38;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_WRSR = 8'h01;

  typedef enum logic [3:0] {
    IDLE,
    WREN_REQ,
    WREN_LO,
    WREN_HI,
    OP_REQ,
    OP_LO,
    OP_HI,
    BUSY_WAIT,
    DONE
  } state_t;

  // Opcodes that modify the array or status register need a Write Enable first.
  function automatic logic needs_wren(input logic [7:0] op);
    return (op == OP_PP) || (op == OP_PP4) || (op == OP_SE) || (op == OP_WRSR);
  endfunction

  // Internal busy time for an opcode; the cycle counts are supplied by the
  // instantiating block so they can be tuned per part.
  function automatic int unsigned busy_time(input logic [7:0] op,
                                            input int unsigned t_pp,
                                            input int unsigned t_se,
                                            input int unsigned t_wrsr);
    case (op)
      OP_PP, OP_PP4: return t_pp;
      OP_SE:         return t_se;
      OP_WRSR:       return t_wrsr;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins.
// Combinational, zero latency.
// No backpressure; en=0 suppresses every grant.
module flash_rr_arb #(
  parameter int N_REQ  = 2,
  parameter int PTR_WD = 1
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [PTR_WD-1:0] ptr,
  input  logic              en,
  output logic [N_REQ-1:0]  gnt,
  output logic [PTR_WD-1:0] next_ptr
);

  logic found;
  int   idx;

  // Scan from ptr upward with wrap; pointer moves just past the winner.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = (idx + 1 >= N_REQ) ? '0 : PTR_WD'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/flash_cmd_sched.sv
// Shares the flash engine command port between requesters, inserting WREN and busy waits.
// Accept to fl_cmd_vld: 1 cycle; busy wait lasts exactly T_* cycles after write opcodes.
// Requests accepted only in IDLE; *_REQ holds fl_cmd/fl_cmd_vld until engine rdy is seen.
module flash_cmd_sched
  import flash_pkg::*;
#(
  parameter int          TOL_WD = 40,
  parameter int          CMD_WD = 8,
  parameter int          N_REQ  = 2,
  parameter int unsigned T_PP   = 4096,
  parameter int unsigned T_SE   = 65536,
  parameter int unsigned T_WRSR = 1024,
  parameter int          TMR_WD = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*TOL_WD-1:0] req_cmd,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [N_REQ-1:0]        req_done,
  output logic [TOL_WD-1:0]       fl_cmd,
  output logic                    fl_cmd_vld,
  input  logic                    fl_cmd_rdy,
  output logic                    busy
);

  localparam int PTR_WD = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TOL_WD-1:0] WREN_WORD = {CMD_WD'(OP_WREN), {(TOL_WD-CMD_WD){1'b0}}};

  state_t              state, state_n;
  logic [PTR_WD-1:0]   rr_ptr, next_ptr;
  logic [TMR_WD-1:0]   timer;
  logic [TOL_WD-1:0]   cmd_r, sel_cmd;
  logic [N_REQ-1:0]    gnt, gnt_r;
  logic [CMD_WD-1:0]   op_r, sel_op;
  logic                arb_en;

  assign arb_en = (state == IDLE);
  assign op_r   = cmd_r[TOL_WD-1 -: CMD_WD];
  assign sel_op = sel_cmd[TOL_WD-1 -: CMD_WD];
  assign busy   = (state != IDLE);

  flash_rr_arb #(
    .N_REQ  (N_REQ),
    .PTR_WD (PTR_WD)
  ) u_arb (
    .req      (req_vld),
    .ptr      (rr_ptr),
    .en       (arb_en),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  // Select the winning requester's command word from the one-hot grant.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_cmd = req_cmd[i*TOL_WD +: TOL_WD];
    end
  end

  // State, grant capture and busy timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      timer  <= '0;
      cmd_r  <= '0;
      gnt_r  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req_vld) begin
        cmd_r  <= sel_cmd;
        gnt_r  <= gnt;
        rr_ptr <= next_ptr;
      end
      if (state == OP_HI && state_n == BUSY_WAIT) begin
        timer <= TMR_WD'(busy_time(8'(op_r), T_PP, T_SE, T_WRSR));
      end else if (state == BUSY_WAIT) begin
        timer <= timer - TMR_WD'(1);
      end
    end
  end

  // Next state and outputs; fl_cmd depends only on state so it cannot glitch mid-handshake.
  always_comb begin
    state_n    = state;
    req_rdy    = '0;
    req_done   = '0;
    fl_cmd     = '0;
    fl_cmd_vld = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = gnt;
        if (|req_vld) state_n = needs_wren(8'(sel_op)) ? WREN_REQ : OP_REQ;
      end
      WREN_REQ: begin
        fl_cmd     = WREN_WORD;
        fl_cmd_vld = 1'b1;
        if (fl_cmd_rdy) state_n = WREN_LO;
      end
      WREN_LO: begin
        fl_cmd = WREN_WORD;
        if (!fl_cmd_rdy) state_n = WREN_HI;
      end
      WREN_HI: begin
        fl_cmd = WREN_WORD;
        if (fl_cmd_rdy) state_n = OP_REQ;
      end
      OP_REQ: begin
        fl_cmd     = cmd_r;
        fl_cmd_vld = 1'b1;
        if (fl_cmd_rdy) state_n = OP_LO;
      end
      OP_LO: begin
        fl_cmd = cmd_r;
        if (!fl_cmd_rdy) state_n = OP_HI;
      end
      OP_HI: begin
        fl_cmd = cmd_r;
        if (fl_cmd_rdy) state_n = needs_wren(8'(op_r)) ? BUSY_WAIT : DONE;
      end
      BUSY_WAIT: begin
        if (timer <= TMR_WD'(1)) state_n = DONE;
      end
      DONE: begin
        req_done = gnt_r;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
